// File: rtl/subpel_pkg.sv
// subpel_pkg: shared sizes, plane codes and bank-state encoding for the subpel block collector
package subpel_pkg;
    localparam int PIX_W   = 8;
    localparam int NUM_PIX = 8;
    localparam int ROW_W   = PIX_W * NUM_PIX;
    localparam int ROWS    = 8;

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    localparam logic [1:0] PLANE_A = 2'd0;
    localparam logic [1:0] PLANE_B = 2'd1;
    localparam logic [1:0] PLANE_C = 2'd2;

    localparam logic [1:0] EMPTY    = 2'd0;
    localparam logic [1:0] FILLING  = 2'd1;
    localparam logic [1:0] FULL     = 2'd2;
    localparam logic [1:0] DRAINING = 2'd3;

    typedef logic [ROW_W-1:0] row_t;
endpackage

// File: rtl/subpel_row_bank.sv
// subpel_row_bank: one ping-pong bank, 3 planes x ROWS rows, row-wide write, (plane,row) read mux
module subpel_row_bank
    import subpel_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [2:0] wr_row_i,
    input  row_t       a_i,
    input  row_t       b_i,
    input  row_t       c_i,
    input  logic [1:0] rd_plane_i,
    input  logic [2:0] rd_row_i,
    output row_t       rd_data_o
);
    row_t mem_a_q [ROWS];
    row_t mem_b_q [ROWS];
    row_t mem_c_q [ROWS];

    // Storage carries no reset; validity is tracked by the bank state in the top level.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_a_q[wr_row_i] <= a_i;
            mem_b_q[wr_row_i] <= b_i;
            mem_c_q[wr_row_i] <= c_i;
        end
    end

    assign rd_data_o = (rd_plane_i == PLANE_C) ? mem_c_q[rd_row_i] :
                       (rd_plane_i == PLANE_B) ? mem_b_q[rd_row_i] : mem_a_q[rd_row_i];
endmodule

// File: rtl/subpel_block_collector.sv
// subpel_block_collector: gathers A/B/C FIR rows into 8x8 blocks and drains them ping-pong as row beats
module subpel_block_collector
    import subpel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] fir_out_a,
    input  logic [ROW_W-1:0] fir_out_b,
    input  logic [ROW_W-1:0] fir_out_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic [1:0]       out_plane,
    output logic [2:0]       out_row_idx,
    output logic             out_last,
    output logic             ovf_err
);
    logic [1:0][1:0] st_q, st_d;
    logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [2:0]      wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [1:0]      rd_plane_q, rd_plane_d;
    logic            ovf_q, ovf_d;
    logic            wr_fire, rd_fire, rd_last;
    row_t            rd_data0, rd_data1;

    assign in_ready  = (st_q[wr_bank_q] == EMPTY) || (st_q[wr_bank_q] == FILLING);
    assign out_valid = (st_q[rd_bank_q] == FULL) || (st_q[rd_bank_q] == DRAINING);
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;
    assign rd_last   = (rd_plane_q == PLANE_C) && (rd_row_q == LAST_ROW);

    // Next-state for both pointer sets; the fill and drain banks are never the same bank when both fire.
    always_comb begin
        st_d       = st_q;
        wr_bank_d  = wr_bank_q;
        wr_row_d   = wr_row_q;
        rd_bank_d  = rd_bank_q;
        rd_row_d   = rd_row_q;
        rd_plane_d = rd_plane_q;
        ovf_d      = ovf_q | (in_valid & ~in_ready);
        if (wr_fire) begin
            wr_row_d          = wr_row_q + 3'd1;
            st_d[wr_bank_q]   = (wr_row_q == LAST_ROW) ? FULL : FILLING;
            wr_bank_d         = (wr_row_q == LAST_ROW) ? ~wr_bank_q : wr_bank_q;
        end
        if (rd_fire) begin
            rd_row_d          = rd_row_q + 3'd1;
            rd_plane_d        = rd_last ? PLANE_A : (rd_row_q == LAST_ROW) ? rd_plane_q + 2'd1 : rd_plane_q;
            st_d[rd_bank_q]   = rd_last ? EMPTY : DRAINING;
            rd_bank_d         = rd_last ? ~rd_bank_q : rd_bank_q;
        end
    end

    // State registers; flush discards any partial or pending block just like reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= '0;
            wr_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_row_q   <= '0;
            rd_plane_q <= PLANE_A;
            ovf_q      <= 1'b0;
        end else if (flush) begin
            st_q       <= '0;
            wr_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_row_q   <= '0;
            rd_plane_q <= PLANE_A;
            ovf_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            wr_bank_q  <= wr_bank_d;
            wr_row_q   <= wr_row_d;
            rd_bank_q  <= rd_bank_d;
            rd_row_q   <= rd_row_d;
            rd_plane_q <= rd_plane_d;
            ovf_q      <= ovf_d;
        end
    end

    subpel_row_bank u_bank0 (
        .clk        (clk),
        .we_i       (wr_fire & ~wr_bank_q),
        .wr_row_i   (wr_row_q),
        .a_i        (fir_out_a),
        .b_i        (fir_out_b),
        .c_i        (fir_out_c),
        .rd_plane_i (rd_plane_q),
        .rd_row_i   (rd_row_q),
        .rd_data_o  (rd_data0)
    );

    subpel_row_bank u_bank1 (
        .clk        (clk),
        .we_i       (wr_fire & wr_bank_q),
        .wr_row_i   (wr_row_q),
        .a_i        (fir_out_a),
        .b_i        (fir_out_b),
        .c_i        (fir_out_c),
        .rd_plane_i (rd_plane_q),
        .rd_row_i   (rd_row_q),
        .rd_data_o  (rd_data1)
    );

    // Stale storage is masked so the beat bus reads zero whenever nothing is offered.
    assign out_row     = out_valid ? (rd_bank_q ? rd_data1 : rd_data0) : '0;
    assign out_plane   = rd_plane_q;
    assign out_row_idx = rd_row_q;
    assign out_last    = out_valid & rd_last;
    assign ovf_err     = ovf_q;
endmodule

// File: tb/tb_subpel_block_collector.sv
// tb_subpel_block_collector: randomized and directed checks against a block-queue reference model
module tb_subpel_block_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] fir_out_a = '0, fir_out_b = '0, fir_out_c = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_row;
    logic [1:0]  out_plane;
    logic [2:0]  out_row_idx;
    logic        out_last;
    logic        ovf_err;

    int checks = 0;
    int failures = 0;
    int in_hs, out_hs;

    subpel_block_collector dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .fir_out_a(fir_out_a), .fir_out_b(fir_out_b), .fir_out_c(fir_out_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_plane(out_plane), .out_row_idx(out_row_idx), .out_last(out_last), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] row;
        logic [1:0]  pl;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    // Reference: completed blocks become a flat queue of 24 beats; at most two blocks may be held.
    beat_t        beats[$];
    logic [191:0] part[$];
    int           full_m;
    bit           ovf_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        beats.delete();
        part.delete();
        full_m = 0;
        ovf_m = 0;
    endtask

    task automatic check_outs(input string tag);
        beat_t b;
        b = (full_m > 0) ? beats[0] : '0;
        chk({tag, ".in_ready"}, in_ready, full_m < 2);
        chk({tag, ".out_valid"}, out_valid, full_m > 0);
        chk({tag, ".out_row"}, out_row, b.row);
        chk({tag, ".out_plane"}, out_plane, b.pl);
        chk({tag, ".out_row_idx"}, out_row_idx, b.idx);
        chk({tag, ".out_last"}, out_last, b.last);
        chk({tag, ".ovf_err"}, ovf_err, ovf_m);
    endtask

    function automatic logic [63:0] rep(input logic [7:0] x);
        return {8{x}};
    endfunction

    task automatic cyc(input string tag, input bit v, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input bit ordy, input bit fl);
        bit ir, ov;
        beat_t bt;
        logic [191:0] r;
        in_valid = v; fir_out_a = a; fir_out_b = b; fir_out_c = c; out_ready = ordy; flush = fl;
        ir = full_m < 2;
        ov = full_m > 0;
        #1;
        in_hs += int'(in_valid & in_ready);
        out_hs += int'(out_valid & out_ready);
        @(posedge clk);
        if (fl) model_clear();
        else begin
            if (ov && ordy) begin
                bt = beats.pop_front();
                if (bt.last) full_m--;
            end
            if (v && ir) begin
                part.push_back({c, b, a});
                if (part.size() == 8) begin
                    for (int p = 0; p < 3; p++)
                        for (int k = 0; k < 8; k++) begin
                            r = part[k];
                            beats.push_back({r[64*p +: 64], 2'(p), 3'(k), (p == 2 && k == 7)});
                        end
                    part.delete();
                    full_m++;
                end
            end else if (v) ovf_m = 1;
        end
        @(negedge clk);
        flush = 1'b0;
        check_outs(tag);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (beats.size() > 0 && n < 200) begin
            cyc(tag, 0, '0, '0, '0, 1, 0);
            n++;
        end
        chk({tag, ".drain_done"}, beats.size(), 0);
    endtask

    task automatic rand_row(input string tag, input bit ordy);
        cyc(tag, 1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, ordy, 0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        in_valid = 0; out_ready = 0; flush = 0;
        rst = 0;
        #1;
        model_clear();
        check_outs({tag, ".imm"});
        @(negedge clk);
        check_outs({tag, ".held"});
        rst = 1;
    endtask

    initial begin
        model_clear();
        // 1: reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            fir_out_a = {$urandom, $urandom}; fir_out_b = {$urandom, $urandom}; fir_out_c = {$urandom, $urandom};
            @(negedge clk);
            check_outs("reset");
        end
        in_valid = 0; out_ready = 0;
        rst = 1;
        @(negedge clk);
        check_outs("post_reset");

        // 2: single directed block
        for (int r = 0; r < 8; r++)
            cyc("t2_fill", 1, rep(8'(8'h10 + r)), rep(8'(8'h20 + r)), rep(8'(8'h30 + r)), 1, 0);
        chk("t2_valid_latency", out_valid, 1);
        chk("t2_first_row", out_row, 64'h1010101010101010);
        for (int i = 0; i < 24; i++) begin
            if (i == 23) begin
                chk("t2_c7_row", out_row, 64'h3737373737373737);
                chk("t2_c7_last", out_last, 1);
            end else chk("t2_not_last", out_last, 0);
            cyc("t2_drain", 0, '0, '0, '0, 1, 0);
        end
        chk("t2_empty", out_valid, 0);

        // 3: backpressure and overflow
        for (int r = 0; r < 17; r++) rand_row("t3_fill", 0);
        chk("t3_in_ready_low", in_ready, 0);
        chk("t3_ovf", ovf_err, 1);
        drain("t3_drain");

        // 4: continuous input, always-ready output
        cyc("t4_flush", 0, '0, '0, '0, 0, 1);
        in_hs = 0; out_hs = 0;
        for (int i = 0; i < 96; i++) rand_row("t4_stream", 1);
        in_hs = in_hs - (in_hs % 8);
        drain("t4_drain");
        chk("t4_ratio", out_hs, 3 * in_hs);

        // 5: random valid/ready with occasional flush
        for (int i = 0; i < 800; i++)
            cyc("t5_rand", ($urandom % 4) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 1'($urandom), ($urandom % 150) == 0);
        drain("t5_drain");

        // 6: async reset mid-block, then flush mid-block
        for (int r = 0; r < 6; r++) rand_row("t6a_fill", 1);
        async_reset("t6a_rst");
        for (int r = 0; r < 8; r++) rand_row("t6a_refill", 1);
        drain("t6a_drain");
        for (int r = 0; r < 6; r++) rand_row("t6b_fill", 1);
        cyc("t6b_flush", 0, '0, '0, '0, 1, 1);
        for (int r = 0; r < 8; r++) rand_row("t6b_refill", 1);
        drain("t6b_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
